// File: rtl/mux_pkg.sv
// Shared definitions for the scanning channel multiplexer.
//   mode_e  : Mode input encoding (manual select / auto-scan)
//   clog2   : ceiling log2, used for deriving counter widths
//   cnt_w   : counter width for a given dwell interval (never below 1 bit)
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic int clog2(input int unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < {32'd0, v}) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cnt_w(input int unsigned dwell);
        return (clog2(dwell) < 1) ? 1 : clog2(dwell);
    endfunction

endpackage

// File: rtl/mux_scan_n_dwell_counter.sv
// Dwell interval counter for the scanning multiplexer.
//   Clock : rising-edge clock
//   Reset : asynchronous active-high reset, count returns to 0
//   En    : advance the count this cycle
//   Clr   : force the count to 0 (has priority over En)
//   Tc    : combinational terminal count, high when En is set and the
//           count sits at DWELL-1 (so the next edge wraps to 0)
module dwell_counter
    import mux_pkg::*;
#(
    parameter int unsigned DWELL = 50000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic En,
    input  logic Clr,
    output logic Tc
);

    localparam int CW = cnt_w(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] count_p1;

    // With DWELL=1 the count never leaves 0, so Tc follows En every cycle.
    assign Tc = En && (count_p1 == LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count_p1 <= '0;
        end else if (Clr) begin
            count_p1 <= '0;
        end else if (En) begin
            count_p1 <= Tc ? '0 : count_p1 + 1'b1;
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel multiplexer with an auto-scan mode that steps through
// the channels on a programmable dwell interval.
//   Clock : rising-edge clock
//   Reset : asynchronous active-high reset
//   Mode  : 0 = manual select on S, 1 = auto-scan
//   Hold  : scan mode only, freezes dwell count and channel index
//   S     : manual channel select
//   W     : flattened channel inputs, channel k = W[k*WIDTH +: WIDTH]
//   F     : registered data of the channel shown on Sel
//   Sel   : registered channel index driving F
//   Adv   : one-cycle pulse on the cycle Sel shows a scan advance
//   Err   : registered, high while the manual select is out of range
module mux_scan_n
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CH    = 8,
    parameter int unsigned SELW  = 3,
    parameter int unsigned DWELL = 50000000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Mode,
    input  logic                  Hold,
    input  logic [SELW-1:0]       S,
    input  logic [CH*WIDTH-1:0]   W,
    output logic [WIDTH-1:0]      F,
    output logic [SELW-1:0]       Sel,
    output logic                  Adv,
    output logic                  Err
);

    localparam logic [SELW:0]   CH_X    = (SELW + 1)'(CH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

    logic             scan;
    logic             first_scan;
    logic             cnt_en;
    logic             cnt_clr;
    logic             tc;
    logic [SELW-1:0]  sel_nxt;
    logic [WIDTH-1:0] f_nxt;
    logic             err_nxt;

    logic [WIDTH-1:0] f_p1;
    logic [SELW-1:0]  sel_p1;
    logic             adv_p1;
    logic             err_p1;
    logic             scan_p1;

    assign scan       = (Mode == MODE_SCAN);
    // scan_p1 resets to 1: the reset state (count 0, Sel 0) is already a
    // valid scan position, so a scan that continues out of reset counts
    // from its first edge instead of spending an extra cycle re-entering.
    assign first_scan = scan && !scan_p1;
    assign cnt_en     = scan && !first_scan && !Hold;
    assign cnt_clr    = !scan || first_scan;

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .Clock (Clock),
        .Reset (Reset),
        .En    (cnt_en),
        .Clr   (cnt_clr),
        .Tc    (tc)
    );

    // Next channel index; manual always wins over a pending terminal count.
    always_comb begin
        sel_nxt = sel_p1;
        if (!scan) begin
            sel_nxt = S;
        end else if (first_scan) begin
            sel_nxt = ({1'b0, sel_p1} >= CH_X) ? '0 : sel_p1;
        end else if (tc) begin
            sel_nxt = (sel_p1 == LAST_CH) ? '0 : sel_p1 + 1'b1;
        end
    end

    // Channel extract on the next index so F and Sel always agree.
    // An out-of-range index matches no channel and yields 0.
    always_comb begin
        f_nxt = '0;
        for (int k = 0; k < CH; k++) begin
            if ({1'b0, sel_nxt} == (SELW + 1)'(k)) begin
                f_nxt = W[k*WIDTH +: WIDTH];
            end
        end
    end

    assign err_nxt = !scan && ({1'b0, S} >= CH_X);

    // ---- stage p1: output registers ----
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            f_p1    <= '0;
            sel_p1  <= '0;
            adv_p1  <= 1'b0;
            err_p1  <= 1'b0;
            scan_p1 <= 1'b1;
        end else begin
            f_p1    <= f_nxt;
            sel_p1  <= sel_nxt;
            adv_p1  <= tc;
            err_p1  <= err_nxt;
            scan_p1 <= scan;
        end
    end

    assign F   = f_p1;
    assign Sel = sel_p1;
    assign Adv = adv_p1;
    assign Err = err_p1;

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N-channel multiplexer that generalises the board's fixed 8-to-1 4-bit selector in data width and channel count. It adds an auto-scan mode that steps through channels on a programmable dwell interval, which lets a single seven-segment/LED output show several sources in turn. It sits between the datapath sources and the display/output drivers. All outputs are registered.

## Interface
- WIDTH, 4, data bits per channel
- CH, 8, number of input channels (2..16)
- SELW, 3, select width; must satisfy 2**SELW >= CH
- DWELL, 50000000, clock cycles per channel in scan mode (>= 1)

- Clock  in  1  rising-edge clock; single clock domain
- Reset  in  1  asynchronous, active-high reset
- Mode  in  1  0 = manual select, 1 = auto-scan
- Hold  in  1  scan mode only: freeze dwell counter and channel index
- S  in  SELW  manual channel select
- W  in  CH*WIDTH  flattened inputs; channel k = W[k*WIDTH +: WIDTH]
- F  out  WIDTH  registered selected data
- Sel  out  SELW  registered index of the channel currently driving F
- Adv  out  1  one-cycle pulse on the cycle Sel advances in scan mode
- Err  out  1  registered; high while manual S >= CH

## Operation
- Reset (asynchronous, any time): F=0, Sel=0, Adv=0, Err=0, dwell count=0. After Reset deasserts, the first edge behaves as a normal cycle from this state.
- Manual (Mode=0):
  - each edge: Sel<=S and F<=channel S; Adv=0; count held at 0.
  - if S>=CH: F<=0, Sel<=S, Err<=1. Otherwise Err<=0.
- Scan (Mode=1):
  - Err<=0. F<=channel indexed by the next value of Sel, so F and Sel always agree.
  - count runs 0..DWELL-1. At DWELL-1 the count returns to 0, Sel<=(Sel==CH-1)?0:Sel+1, and Adv<=1.
  - Hold=1: count and Sel are frozen and Adv=0. F keeps tracking the live data on the current channel.
  - DWELL=1: Sel advances every cycle.
- Mode 0->1: on the first scan edge, count<=0 and scanning starts from the current Sel. If Sel>=CH, Sel<=0 on that edge.
- Mode 1->0: on the next edge Sel<=S. The count clears.
- Simultaneous terminal count and Mode falling to 0: manual wins (Sel<=S, Adv=0).

## Timing
- Latency of 1 cycle from W/S/Mode to F/Sel/Err.
- Adv is registered. It is high in the same cycle Sel first shows the new index.
- In scan mode a channel is held for exactly DWELL cycles unless Hold is asserted.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package/include mux_pkg: mode encodings MODE_MANUAL=0 and MODE_SCAN=1, and a clog2 helper function for deriving counter widths.
- Counter width: clog2(DWELL), minimum 1.
- One sub-module, dwell_counter. Parameter DWELL; inputs Clock, Reset, En, Clr; output Tc, a combinational terminal-count flag. The top level registers Tc into Adv and owns the Sel/F registers and the channel-extract loop.

## Test plan
- Reset mid-scan: with WIDTH=4, CH=8, DWELL=3, assert Reset while Sel=5 -> F=0, Sel=0, Adv=0 immediately (asynchronously). After release, Sel=1 three edges later.
- Manual select: W channel k = k+3, S=6 -> F=9 and Sel=6 one edge later. S=2 -> F=5 on the next edge, Err=0.
- Out-of-range select: CH=6, SELW=3, S=7 -> F=0, Sel=7, Err=1. Then S=1 -> Err=0 and F=channel 1.
- Scan wrap: CH=8, DWELL=2, Mode=1 from Sel=6 -> Sel sequence 6,6,7,7,0,0,1. Adv pulses on the cycles Sel becomes 7, 0 and 1.
- Hold: scan with DWELL=4, Hold=1 for 10 cycles at Sel=3 -> Sel stays 3 and Adv=0. Changing channel 3 data from 0xA to 0x5 gives F=0x5 one edge later. After Hold releases, Sel=4 after 4 more edges.
- Mode race: Mode falls on the cycle the count reaches DWELL-1 with S=0 -> Sel=0, Adv=0 and no scan advance.
